// File: rtl/sipo_sync_rst.sv
//------------------------------------------------------------------------------
// Module      : sipo_sync_rst
// Description : Strobed serial-in, parallel-out deserializer with a valid/ready
//               output port and an overrun pulse for words lost to
//               back-pressure. Optional even-parity trailer bit is enabled by
//               defining SIPO_SYNC_RST_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sipo_sync_rst #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             en,
    output logic [WIDTH-1:0] word,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_SYNC_RST_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [CW-1:0] c_last = CW'(NBITS - 1);
    localparam logic [CW-1:0] c_one  = CW'(1);

    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_word;
    logic             r_valid;
    logic             r_overrun;

    logic             w_last;
    logic             w_shift;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_done_word;
    logic             w_out_free;

    assign w_last     = en && (r_cnt == c_last);
    assign w_shifted  = {d, r_sr[WIDTH-1:1]};
    assign w_out_free = !r_valid || ready;

`ifdef SIPO_SYNC_RST_PARITY_EN
    // The trailing parity bit is strobed but never enters the data register.
    logic r_parity_err;
    logic w_parity_bad;

    assign w_shift      = en && !w_last;
    assign w_done_word  = r_sr;
    assign w_parity_bad = (^r_sr) ^ d;
    assign parity_err   = r_parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_last && w_out_free) begin
            r_parity_err <= w_parity_bad;
        end
    end
`else
    logic w_unused_sr0;

    assign w_shift      = en;
    assign w_done_word  = w_shifted;
    assign w_unused_sr0 = r_sr[0];
    assign parity_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_shift) begin
                r_sr <= w_shifted;
            end
            if (en) begin
                r_cnt <= w_last ? '0 : (r_cnt + c_one);
            end
            // A completed word either takes the output or is dropped;
            // collection itself never waits on the consumer.
            if (w_last) begin
                if (w_out_free) begin
                    r_word  <= w_done_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign word    = r_word;
    assign valid   = r_valid;
    assign overrun = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_sipo_sync_rst.sv
//------------------------------------------------------------------------------
// Module      : tb_sipo_sync_rst
// Description : Self-checking bench for sipo_sync_rst against a bit-queue
//               reference model (WIDTH = 8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_sync_rst;

    localparam int W = 8;
`ifdef SIPO_SYNC_RST_PARITY_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         d = 1'b0;
    logic         en = 1'b0;
    logic         ready = 1'b0;
    logic [W-1:0] word;
    logic         valid;
    logic         overrun;
    logic         parity_err;

    int nchecks = 0;
    int nerrors = 0;

    // Reference model: received bits are queued and assembled when enough arrive.
    bit           q[$];
    logic         m_valid = 1'b0;
    logic [W-1:0] m_word = '0;
    logic         m_ovr = 1'b0;
    logic         m_perr = 1'b0;

    sipo_sync_rst #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .en         (en),
        .word       (word),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic md, input logic men, input logic mrdy, input logic mrst);
        bit           done;
        logic [W-1:0] nw;
        int           ones;
        done = 1'b0;
        nw   = '0;
        ones = 0;
        if (mrst) begin
            q.delete();
            m_valid = 1'b0;
            m_word  = '0;
            m_ovr   = 1'b0;
            m_perr  = 1'b0;
            return;
        end
        m_ovr = 1'b0;
        if (men) begin
            q.push_back(md);
            if (q.size() == NB) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) nw[i] = q[i];
                for (int i = 0; i < NB; i++) ones += int'(q[i]);
                q.delete();
            end
        end
        if (done) begin
            if (!m_valid || mrdy) begin
                m_valid = 1'b1;
                m_word  = nw;
`ifdef SIPO_SYNC_RST_PARITY_EN
                m_perr  = (ones % 2) == 1;
`endif
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && mrdy) begin
            m_valid = 1'b0;
        end
    endtask

    // Apply inputs, advance one edge, update model, settle before sampling.
    task automatic step(input logic sd, input logic sen, input logic srdy, input logic srst);
        d     = sd;
        en    = sen;
        ready = srdy;
        rst   = srst;
        @(posedge clk);
        model_edge(sd, sen, srdy, srst);
        #1;
    endtask

    function automatic logic par_bit(input logic [W-1:0] v, input bit bad);
        return (^v) ^ logic'(bad);
    endfunction

    // Sends one frame (data bits LSB first, plus parity when enabled).
    // ready is applied as rdy_body except on the completing strobe.
    task automatic send_word(input logic [W-1:0] v, input logic rdy_body, input logic rdy_last, input bit bad_par);
        logic [NB-1:0] frame;
`ifdef SIPO_SYNC_RST_PARITY_EN
        frame = {par_bit(v, bad_par), v};
`else
        frame = v;
        if (bad_par) frame = v;
`endif
        for (int i = 0; i < NB; i++)
            step(frame[i], 1'b1, (i == NB - 1) ? rdy_last : rdy_body, 1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        nchecks++;
        if (word !== '0 || valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin
            nerrors++;
            $display("FAIL reset: word=%h valid=%b ovr=%b perr=%b, want 00 0 0 0", word, valid, overrun, parity_err);
        end
    endtask

    task automatic test_basic_a5();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(8'hA5, 1'b1, 1'b1, 1'b0);
        nchecks++;
        if (valid !== 1'b1 || word !== 8'hA5 || overrun !== 1'b0) begin
            nerrors++;
            $display("FAIL a5_complete: valid=%b word=%h ovr=%b, want 1 a5 0", valid, word, overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        nchecks++;
        if (valid !== 1'b0 || word !== 8'hA5) begin
            nerrors++;
            $display("FAIL a5_consume: valid=%b word=%h, want 0 a5", valid, word);
        end
    endtask

    task automatic test_gaps();
        logic [NB-1:0] frame;
        step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SIPO_SYNC_RST_PARITY_EN
        frame = {par_bit(8'h3C, 1'b0), 8'h3C};
`else
        frame = 8'h3C;
`endif
        for (int i = 0; i < NB; i++) begin
            step(frame[i], 1'b1, 1'b0, 1'b0);
            if (i < NB - 1) begin
                nchecks++;
                if (valid !== 1'b0) begin
                    nerrors++;
                    $display("FAIL gap_early_strobe%0d: valid=%b, want 0", i, valid);
                end
            end
            step(1'($urandom), 1'b0, 1'b0, 1'b0);
        end
        nchecks++;
        if (valid !== 1'b1 || word !== 8'h3C) begin
            nerrors++;
            $display("FAIL gap_word: valid=%b word=%h, want 1 3c", valid, word);
        end
    endtask

    task automatic test_overrun();
        int pulses;
        pulses = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        nchecks++;
        if (valid !== 1'b1 || word !== 8'h11 || overrun !== 1'b0) begin
            nerrors++;
            $display("FAIL ovr_first: valid=%b word=%h ovr=%b, want 1 11 0", valid, word, overrun);
        end
        for (int i = 0; i < NB; i++) begin
            step(((8'h22 >> i) & 1) != 0 || (i == W && (^8'h22) == 1'b1), 1'b1, 1'b0, 1'b0);
            pulses += int'(overrun);
        end
        nchecks++;
        if (overrun !== 1'b1 || valid !== 1'b1 || word !== 8'h11) begin
            nerrors++;
            $display("FAIL ovr_drop: ovr=%b valid=%b word=%h, want 1 1 11", overrun, valid, word);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        pulses += int'(overrun);
        nchecks++;
        if (valid !== 1'b0 || word !== 8'h11 || pulses != 1) begin
            nerrors++;
            $display("FAIL ovr_release: valid=%b word=%h pulses=%0d, want 0 11 1", valid, word, pulses);
        end
    endtask

    task automatic test_ready_on_complete();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b1, 1'b0);
        nchecks++;
        if (valid !== 1'b1 || word !== 8'h22 || overrun !== 1'b0) begin
            nerrors++;
            $display("FAIL ready_edge: valid=%b word=%h ovr=%b, want 1 22 0", valid, word, overrun);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(8'hF0, 1'b0, 1'b0, 1'b0);
        nchecks++;
        if (valid !== 1'b1 || word !== 8'hF0) begin
            nerrors++;
            $display("FAIL rst_partial: valid=%b word=%h, want 1 f0", valid, word);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1);
        nchecks++;
        if (valid !== 1'b0 || word !== '0 || overrun !== 1'b0) begin
            nerrors++;
            $display("FAIL rst_held: valid=%b word=%h ovr=%b, want 0 00 0", valid, word, overrun);
        end
    endtask

    task automatic test_parity();
`ifdef SIPO_SYNC_RST_PARITY_EN
        step(1'b0, 1'b0, 1'b1, 1'b1);
        send_word(8'h07, 1'b1, 1'b1, 1'b0);
        nchecks++;
        if (word !== 8'h07 || parity_err !== 1'b0) begin
            nerrors++;
            $display("FAIL parity_good: word=%h perr=%b, want 07 0", word, parity_err);
        end
        send_word(8'h07, 1'b1, 1'b1, 1'b1);
        nchecks++;
        if (word !== 8'h07 || valid !== 1'b1 || parity_err !== 1'b1) begin
            nerrors++;
            $display("FAIL parity_bad: word=%h valid=%b perr=%b, want 07 1 1", word, valid, parity_err);
        end
`else
        int seen;
        seen = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 64; i++) begin
            step(1'($urandom), 1'b1, 1'($urandom), 1'b0);
            seen += int'(parity_err);
        end
        nchecks++;
        if (seen != 0) begin
            nerrors++;
            $display("FAIL parity_tied: parity_err high %0d cycles, want 0", seen);
        end
`endif
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 59) == 0));
            nchecks++;
            if (valid !== m_valid || word !== m_word || overrun !== m_ovr || parity_err !== m_perr) begin
                nerrors++;
                if (bad < 10)
                    $display("FAIL random_cyc%0d: valid=%b word=%h ovr=%b perr=%b, want %b %h %b %b",
                             i, valid, word, overrun, parity_err, m_valid, m_word, m_ovr, m_perr);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_a5();
        test_gaps();
        test_overrun();
        test_ready_on_complete();
        test_reset_mid();
        test_parity();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sipo_sync_rst.md
# sipo_sync_rst

Serial-in, parallel-out deserializer: the receiving end of a single-bit serial stream gated by a bit strobe, as produced by the team's registered serial drivers. It shifts in `WIDTH` strobed bits LSB-first, presents the assembled word on a valid/ready output port, and flags words lost to back-pressure. It sits in the sequential common-components library beside the flop primitives and serves as the capture side of serial links and test harnesses.

## Interface
Parameters:
- `WIDTH`, default 8: data bits per word; legal range 2..32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `d`, input, 1: serial data bit.
- `en`, input, 1: bit strobe; `d` is sampled only on edges where `en`=1.
- `word`, output, `WIDTH`: assembled word; bit 0 is the first bit received.
- `valid`, output, 1: `word` holds an unconsumed word.
- `ready`, input, 1: consumer accepts `word` on edges where `valid`=1 and `ready`=1.
- `overrun`, output, 1: one-cycle pulse when a completed word is dropped.
- `parity_err`, output, 1: parity status of the word on `word`; see Configuration.

## Operation
- Internal state: shift register `sr[WIDTH-1:0]` and bit counter `cnt` of width `$clog2(WIDTH+1)`.
- On an edge with `en`=1, `d` enters the MSB of `sr` and `sr` shifts right; `cnt` increments.
- Word completes on the edge that samples the last bit (`cnt`=WIDTH-1 with `en`=1). On that edge `cnt` returns to 0.
- On completion, if the output is free, the completed word loads `word` and `valid` is set.
  - The output is free when `valid`=0, or when `valid`=1 and `ready`=1 on the same edge.
- If completion occurs while `valid`=1 and `ready`=0:
  - the new word is discarded;
  - `word` and `valid` are unchanged;
  - `overrun` pulses for one cycle.
- Consumption without completion (`valid`=1, `ready`=1) clears `valid`. `word` holds its last value.
- `ready` has no effect while `valid`=0.
- Bit collection never stalls. Back-pressure only causes dropped words.

## Timing
- Reset values: `word`=0, `valid`=0, `overrun`=0, `parity_err`=0; `sr`=0, `cnt`=0.
- Reset mid-word discards the partial word. Reset while `valid`=1 discards the held word. `rst` overrides `en` and `ready` on the same edge.
- Latency: `valid` is high in the cycle after the edge that samples the last bit.
- Back-to-back words with `en` held high: a new word every `WIDTH` cycles, with no bubble.
- `overrun` is high exactly in the cycle after the dropping edge. It never coincides with a `word` update.
- Gaps in `en` of any length are allowed mid-word. Partial state is retained.

## Configuration
- Macro `SIPO_SYNC_RST_PARITY_EN`.
- Defined:
  - Each word is `WIDTH` data bits followed by one strobed even-parity bit.
  - Completion happens on the parity-bit edge (`cnt` runs 0..WIDTH); the counter widens to hold WIDTH.
  - `parity_err` loads together with `word`: 1 if the XOR of the data bits and the parity bit is 1.
  - Words with bad parity are still delivered.
- Not defined:
  - No parity bit; completion happens on the `WIDTH`-th bit.
  - `parity_err` is tied to 0.

## Test plan
Scenarios use `WIDTH`=8.
- Reset, then `en`=1 for 8 cycles shifting 0xA5 LSB-first (1,0,1,0,0,1,0,1), with `ready`=1 -> `valid` high for one cycle the cycle after the 8th bit, `word`=0xA5, `overrun`=0.
- 0x3C sent with `en` toggling 1/0 every cycle -> `word`=0x3C, `valid` rises one cycle after the 8th strobed bit, and there is no early completion.
- `ready`=0, then 0x11 followed by 0x22 back-to-back -> `word` stays 0x11 with `valid`=1, `overrun` pulses once after the 16th bit. Raising `ready` then clears `valid`.
- 0x11 held with `ready`=0; raise `ready` on the exact edge 0x22 completes -> `word`=0x22, `valid` stays 1, `overrun`=0.
- 5 bits sent, `rst` pulsed, then 0xF0 sent -> `word`=0xF0 and the partial word does not leak. `rst` asserted while `valid`=1 -> `valid`=0 and `word`=0 next cycle.
- With `SIPO_SYNC_RST_PARITY_EN`: 0x07 plus parity 1 -> `parity_err`=0; 0x07 plus parity 0 -> `word`=0x07 and `parity_err`=1. Without the macro, `parity_err` stays 0 throughout.
